// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data load/store; data wins until it has starved fetch MAX_DM_RUN times.
// Grants are same-cycle combinational, read data returns one cycle after the grant; a losing requester simply holds its request.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MAX_DM_RUN = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_DM} rsp_t;

  localparam logic [3:0] RUN_CAP = 4'(MAX_DM_RUN);

  rsp_t       rsp_sel;
  logic [3:0] dm_run;
  logic       if_elig;
  logic       grant_if;
  logic       grant_dm;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  assign if_elig  = if_req && !halted;
  assign grant_dm = rst_n && dm_req && !(if_elig && (dm_run == RUN_CAP));
  assign grant_if = rst_n && if_elig && !grant_dm;

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign if_stall  = rst_n && if_elig && !grant_if;

  assign mem_en    = grant_if || grant_dm;
  assign mem_we    = grant_dm && dm_we;
  assign mem_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_dm ? dm_wdata : '0;

  assign if_rvalid = rst_n && (rsp_sel == RSP_IF);
  assign dm_rvalid = rst_n && (rsp_sel == RSP_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sel <= RSP_NONE;
      dm_run  <= '0;
    end else begin
      if (grant_if)
        rsp_sel <= RSP_IF;
      else if (grant_dm && !dm_we)
        rsp_sel <= RSP_DM;
      else
        rsp_sel <= RSP_NONE;

      // Only counts data wins that actually made fetch wait.
      if (grant_if || !if_elig)
        dm_run <= '0;
      else if (grant_dm)
        dm_run <= dm_run + 4'd1;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 10, memory word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_DM_RUN, default 4, max consecutive data grants while fetch waits; legal range 1..15.
REQ-004 clk1  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 halted  in  1  pipeline halted; fetch requests ignored while high.
REQ-007 if_req  in  1  instruction-fetch read request.
REQ-008 if_addr  in  AW  fetch word address.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  if_rdata valid.
REQ-011 if_rdata  out  DW  fetched instruction.
REQ-012 if_stall  out  1  fetch requested but not granted this cycle.
REQ-013 dm_req  in  1  data (LW/SW) request.
REQ-014 dm_we  in  1  1 = store, 0 = load.
REQ-015 dm_addr  in  AW  data word address.
REQ-016 dm_wdata  in  DW  store data.
REQ-017 dm_gnt  out  1  data request accepted this cycle.
REQ-018 dm_rvalid  out  1  dm_rdata valid (loads only).
REQ-019 dm_rdata  out  DW  load data.
REQ-020 mem_en, mem_we  out  1 each  single-port RAM enable / write enable.
REQ-021 mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW  (RAM read data, 1-cycle latency).

Function
REQ-022 One RAM access per cycle max; grant combinational from current requests and registered state.
REQ-023 Eligible fetch = if_req && !halted; eligible data = dm_req.
REQ-024 Only data eligible -> dm_gnt; only fetch eligible -> if_gnt; neither -> mem_en=0, no grant.
REQ-025 Both eligible: dm_gnt unless dm_run == MAX_DM_RUN, then if_gnt.
REQ-026 dm_run (4-bit): +1 on dm_gnt while fetch eligible; cleared on if_gnt or whenever fetch not eligible; never exceeds MAX_DM_RUN.
REQ-027 On grant, mem_en=1 and mem_addr/mem_we/mem_wdata driven from granted port in same cycle; mem_we=dm_we for data, 0 for fetch; mem_wdata=dm_wdata when data granted, else 0.
REQ-028 Response owner register rsp_sel ∈ {NONE, IF, DM}: next = IF on if_gnt, DM on dm_gnt with dm_we=0, else NONE.
REQ-029 rsp_sel=IF -> if_rvalid=1, if_rdata=mem_rdata; rsp_sel=DM -> dm_rvalid=1, dm_rdata=mem_rdata; non-owner rdata outputs 0.
REQ-030 Read latency: grant in cycle N, rvalid in cycle N+1; back-to-back grants give rvalid every cycle.
REQ-031 Stores produce no rvalid; store to address A followed by load of A returns new data.
REQ-032 Requester holds req/addr/wdata stable until gnt; gnt is a single-cycle pulse per accepted access.
REQ-033 if_stall = if_req && !halted && !if_gnt.
REQ-034 halted rising while fetch pending: no further if_gnt; a fetch response already in flight still returns next cycle.

Reset
REQ-035 rst_n low: rsp_sel=NONE, dm_run=0 immediately; all gnt/rvalid/rdata/mem_* outputs 0 while rst_n low.
REQ-036 Reset asserted mid-access drops the in-flight response; no rvalid in first cycle after release.
REQ-037 First grant possible in first rising edge cycle with rst_n high.

Verification
REQ-038 RAM[120]=85; dm_req load addr 120 alone -> dm_gnt cycle N, dm_rvalid N+1, dm_rdata=85.
REQ-039 Store 130 to addr 121, then load 121 -> dm_rvalid with 130; no rvalid on store cycle+1.
REQ-040 if_req and dm_req held high continuously, MAX_DM_RUN=4 -> grant pattern DM,DM,DM,DM,IF repeating; if_stall high on DM cycles.
REQ-041 Only if_req, addrs 0..7 one per cycle -> if_gnt every cycle, if_rdata=RAM[k] one cycle later, if_stall=0.
REQ-042 halted=1 with if_req=1 -> no if_gnt, if_stall=0, dm requests still served; halted=0 resumes fetch next cycle.
REQ-043 rst_n pulsed low the cycle after a load grant -> no dm_rvalid, dm_run=0, outputs 0 during reset.
